// File: rtl/div_unit_pkg.sv
// Shared types for the iterative divider: FSM states, control-bus bit positions
// and the quotient/remainder pair held by the operand-reuse cache.
package div_unit_pkg;

  typedef enum logic [2:0] {S_IDLE, S_NORM, S_ITER, S_FIX, S_DONE} state_e;

  localparam int CTL_MUL = 0;
  localparam int CTL_SGN = 1;
  localparam int CTL_REM = 3;
  localparam int CTL_W   = 4;
  localparam int CTL_B   = 5;

  localparam int DIV_MAXW = 64;

  typedef struct packed {
    logic [DIV_MAXW-1:0] q;
    logic [DIV_MAXW-1:0] r;
  } div_res_t;

endpackage

// File: rtl/div_unit_step.sv
// One iteration of the divider: BPC chained restoring subtract stages.
module div_step
  import div_unit_pkg::*;
#(
  parameter int RV  = 64,
  parameter int BPC = 2
) (
  input  logic [RV-1:0]  rem_i,
  input  logic [RV-1:0]  dvd_i,
  input  logic [RV-1:0]  den_i,
  output logic [RV-1:0]  rem_o,
  output logic [RV-1:0]  dvd_o,
  output logic [BPC-1:0] q_o
);

  logic [RV:0]   r;
  logic [RV-1:0] d;

  // The partial remainder is one bit wider so the shifted value can exceed den.
  always_comb begin
    r   = {1'b0, rem_i};
    d   = dvd_i;
    q_o = '0;
    for (int i = BPC - 1; i >= 0; i--) begin
      r = {r[RV-1:0], d[RV-1]};
      d = {d[RV-2:0], 1'b0};
      if (r >= {1'b0, den_i}) begin
        r      = r - {1'b0, den_i};
        q_o[i] = 1'b1;
      end
    end
    rem_o = r[RV-1:0];
    dvd_o = d;
  end

endmodule

// File: rtl/div_unit.sv
// Iterative integer divider: leading-zero normalise, BPC bits/cycle, sign fix-up,
// div/rem reuse cache and a held writeback result with commit-slot kill.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int RV         = 64,
  parameter int BPC        = 2,
  parameter int REUSE      = 1,
  parameter int NHART      = 1,
  parameter int LNHART     = 0,
  parameter int NCOMMIT    = 32,
  parameter int LNCOMMIT   = 5,
  parameter int CNTRL_SIZE = 7
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 enable,
  input  logic                                 rv32,
  input  logic [CNTRL_SIZE-1:0]                control,
  input  logic [LNCOMMIT-1:0]                  rd,
  input  logic                                 makes_rd,
  input  logic [RV-1:0]                        r1,
  input  logic [RV-1:0]                        r2,
  input  logic [((LNHART > 0) ? LNHART : 1)-1:0] hart,
  input  logic [NCOMMIT-1:0]                   commit_kill_0,
  input  logic                                 res_ack,
  output logic                                 res_valid,
  output logic [RV-1:0]                        result,
  output logic [LNCOMMIT-1:0]                  res_rd,
  output logic [NHART-1:0]                     res_makes_rd,
  output logic                                 busy,
  output logic [((LNHART > 0) ? LNHART : 1)-1:0] busy_hart,
  output logic [LNCOMMIT-1:0]                  busy_rd
);

  localparam int HW   = (LNHART > 0) ? LNHART : 1;
  localparam int CW   = $clog2(RV + 1);
  localparam int LBPC = $clog2(BPC);

  function automatic logic [RV-1:0] ext32(input logic [RV-1:0] x, input logic s);
    logic [RV-1:0] y;
    y = x;
    for (int i = 32; i < RV; i++) y[i] = s & x[31];
    return y;
  endfunction

  state_e             state_q, state_d;
  logic [LNCOMMIT-1:0] rd_q, rd_d;
  logic [HW-1:0]      hart_q, hart_d;
  logic               mk_q, mk_d, remop_q, remop_d, w_q, w_d, sgn_q, sgn_d;
  logic               negq_q, negq_d, negr_q, negr_d;
  logic [RV-1:0]      r1_q, r1_d, r2_q, r2_d, den_q, den_d, dvd_q, dvd_d;
  logic [RV-1:0]      rem_q, rem_d, quo_q, quo_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               cv_q, cv_d, c_w_q, c_w_d, c_sgn_q, c_sgn_d;
  logic [RV-1:0]      c_r1_q, c_r1_d, c_r2_q, c_r2_d;
  div_res_t           c_res_q, c_res_d;

  logic [RV-1:0]  st_rem, st_dvd;
  logic [BPC-1:0] st_q;

  div_step #(.RV(RV), .BPC(BPC)) u_step (
    .rem_i (rem_q), .dvd_i (dvd_q), .den_i (den_q),
    .rem_o (st_rem), .dvd_o (st_dvd), .q_o (st_q)
  );

  // Issue-side decode: W ops pre-extend to RV bits so one datapath serves both widths.
  logic          w_i, sgn_i, sa, sb, issue_go, kill, done_ok, hit;
  logic [RV-1:0] a_ext, b_ext, ma, mb, hit_q, hit_r;

  assign w_i      = rv32 | control[CTL_W];
  assign sgn_i    = control[CTL_SGN];
  assign a_ext    = w_i ? ext32(r1, sgn_i) : r1;
  assign b_ext    = w_i ? ext32(r2, sgn_i) : r2;
  assign sa       = sgn_i & a_ext[RV-1];
  assign sb       = sgn_i & b_ext[RV-1];
  assign ma       = sa ? -a_ext : a_ext;
  assign mb       = sb ? -b_ext : b_ext;
  assign kill     = (state_q != S_IDLE) && commit_kill_0[rd_q];
  assign done_ok  = (state_q == S_DONE) && res_ack && !kill;
  assign issue_go = enable && !control[CTL_B] && !control[CTL_MUL] && !commit_kill_0[rd]
                    && ((state_q == S_IDLE) || ((state_q == S_DONE) && res_ack));

  // The op retiring this cycle is visible to the cache lookup, so a div followed
  // immediately by its rem still hits.
  always_comb begin
    if (done_ok) begin
      hit   = (REUSE != 0) && r1_q == r1 && r2_q == r2 && w_q == w_i && sgn_q == sgn_i;
      hit_q = quo_q;
      hit_r = rem_q;
    end else begin
      hit   = (REUSE != 0) && cv_q && c_r1_q == r1 && c_r2_q == r2 && c_w_q == w_i && c_sgn_q == sgn_i;
      hit_q = c_res_q.q[RV-1:0];
      hit_r = c_res_q.r[RV-1:0];
    end
  end

  logic [CW-1:0] nbits, iters, shamt;
  always_comb begin
    nbits = '0;
    for (int i = 0; i < RV; i++) if (dvd_q[i]) nbits = CW'(i + 1);
    iters = (nbits + CW'(BPC - 1)) >> LBPC;
    shamt = CW'(RV) - (iters << LBPC);
  end

  always_comb begin
    state_d = state_q;  rd_d = rd_q;  hart_d = hart_q;  mk_d = mk_q;
    remop_d = remop_q;  w_d = w_q;    sgn_d = sgn_q;    negq_d = negq_q;  negr_d = negr_q;
    r1_d = r1_q;  r2_d = r2_q;  den_d = den_q;  dvd_d = dvd_q;
    rem_d = rem_q;  quo_d = quo_q;  cnt_d = cnt_q;
    cv_d = cv_q;  c_w_d = c_w_q;  c_sgn_d = c_sgn_q;
    c_r1_d = c_r1_q;  c_r2_d = c_r2_q;  c_res_d = c_res_q;
    unique case (state_q)
      S_NORM: begin
        dvd_d   = dvd_q << shamt;
        cnt_d   = iters - CW'(1);
        state_d = S_ITER;
      end
      S_ITER: begin
        dvd_d = st_dvd;
        rem_d = st_rem;
        quo_d = {quo_q[RV-BPC-1:0], st_q};
        if (cnt_q == '0) state_d = (negq_q || negr_q) ? S_FIX : S_DONE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_FIX: begin
        if (negq_q) quo_d = -quo_q;
        if (negr_q) rem_d = -rem_q;
        state_d = S_DONE;
      end
      S_DONE: if (res_ack) state_d = S_IDLE;
      default: ;
    endcase
    if (kill) state_d = S_IDLE;
    if (done_ok) begin
      cv_d      = 1'b1;
      c_w_d     = w_q;
      c_sgn_d   = sgn_q;
      c_r1_d    = r1_q;
      c_r2_d    = r2_q;
      c_res_d.q = DIV_MAXW'(quo_q);
      c_res_d.r = DIV_MAXW'(rem_q);
    end
    if (issue_go) begin
      rd_d = rd;  hart_d = hart;  mk_d = makes_rd;  remop_d = control[CTL_REM];
      w_d = w_i;  sgn_d = sgn_i;  r1_d = r1;  r2_d = r2;
      negq_d = sa ^ sb;  negr_d = sa;
      den_d = mb;  dvd_d = ma;  rem_d = '0;  quo_d = '0;
      state_d = S_DONE;
      if (mb == '0) begin
        quo_d = '1;
        rem_d = a_ext;
      end else if (ma == '0) begin
        quo_d = '0;
      end else if (hit) begin
        quo_d = hit_q;
        rem_d = hit_r;
      end else begin
        state_d = S_NORM;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cv_q    <= cv_d;
    end
  end

  always_ff @(posedge clk) begin
    rd_q <= rd_d;  hart_q <= hart_d;  mk_q <= mk_d;  remop_q <= remop_d;
    w_q <= w_d;  sgn_q <= sgn_d;  negq_q <= negq_d;  negr_q <= negr_d;
    r1_q <= r1_d;  r2_q <= r2_d;  den_q <= den_d;  dvd_q <= dvd_d;
    rem_q <= rem_d;  quo_q <= quo_d;  cnt_q <= cnt_d;
    c_w_q <= c_w_d;  c_sgn_q <= c_sgn_d;  c_r1_q <= c_r1_d;  c_r2_q <= c_r2_d;
    c_res_q <= c_res_d;
  end

  logic [RV-1:0] sel;
  assign sel       = remop_q ? rem_q : quo_q;
  assign result    = w_q ? ext32(sel, 1'b1) : sel;
  assign res_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign res_rd    = rd_q;
  assign busy_rd   = rd_q;
  assign busy_hart = hart_q;

  always_comb begin
    res_makes_rd = '0;
    for (int h = 0; h < NHART; h++)
      res_makes_rd[h] = res_valid && mk_q && !commit_kill_0[rd_q] && (hart_q == HW'(h));
  end

  logic unused_ctl;
  assign unused_ctl = ^control;

endmodule
